// File: rtl/jtag_cfg_xfer_pkg.sv
// Shared types and constants for the JTAG configuration word clock-domain transfer.
package jtag_cfg_xfer_pkg;

    localparam int unsigned SYNC_STAGES_MIN = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_REL  = 2'd2
    } src_state_e;

    typedef enum logic {
        D_IDLE = 1'b0,
        D_ACK  = 1'b1
    } dst_state_e;

endpackage

// File: rtl/jtag_cfg_xfer_sync.sv
// Single-bit multi-flop synchronizer, async active-low reset to 0.
module jtag_cfg_xfer_sync
    import jtag_cfg_xfer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    // Depths below the minimum are raised to it rather than producing a broken chain.
    localparam int unsigned N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

    logic [N-1:0] sync_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N-2:0], d_i};
        end
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/jtag_cfg_xfer_ctrl.sv
// TCK -> SoC clock transfer of the JTAG configuration word over a 4-phase req/ack handshake.
// Optional macro JTAG_CFG_XFER_PENDING_EN adds a one-deep pending buffer (newest wins).
module jtag_cfg_xfer_ctrl
    import jtag_cfg_xfer_pkg::*;
#(
    parameter int unsigned      WIDTH       = 9,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic             tck_i,
    input  logic             trst_ni,
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             upd_valid_i,
    input  logic [WIDTH-1:0] upd_data_i,
    input  logic             clr_ovr_i,
    output logic             busy_o,
    output logic             ovr_o,
    output logic [WIDTH-1:0] cfg_o,
    output logic             cfg_valid_o
);

    // ---------------- TCK domain ----------------
    src_state_e       src_state_q, src_state_d;
    logic             req_q, req_d;
    logic [WIDTH-1:0] xfer_q, xfer_d;
    logic             ovr_q, ovr_d;
    logic             busy_q, busy_d;
    logic             ack_sync;
    logic             busy_c;

`ifdef JTAG_CFG_XFER_PENDING_EN
    logic             pend_vld_q, pend_vld_d;
    logic [WIDTH-1:0] pend_q, pend_d;

    assign busy_c = (src_state_q != S_IDLE) || pend_vld_q;
`else
    assign busy_c = (src_state_q != S_IDLE);
`endif

    // Source FSM next state: launch, wait for ack, wait for release; updates arriving while busy.
    always_comb begin
        src_state_d = src_state_q;
        req_d       = req_q;
        xfer_d      = xfer_q;
        ovr_d       = clr_ovr_i ? 1'b0 : ovr_q;
`ifdef JTAG_CFG_XFER_PENDING_EN
        pend_vld_d  = pend_vld_q;
        pend_d      = pend_q;
`endif
        case (src_state_q)
            S_IDLE: begin
`ifdef JTAG_CFG_XFER_PENDING_EN
                if (pend_vld_q) begin
                    xfer_d      = pend_q;
                    req_d       = 1'b1;
                    src_state_d = S_REQ;
                    pend_vld_d  = 1'b0;
                end else
`endif
                if (upd_valid_i) begin
                    xfer_d      = upd_data_i;
                    req_d       = 1'b1;
                    src_state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (ack_sync) begin
                    req_d       = 1'b0;
                    src_state_d = S_REL;
                end
            end
            S_REL: begin
                if (!ack_sync) begin
                    src_state_d = S_IDLE;
`ifdef JTAG_CFG_XFER_PENDING_EN
                    if (pend_vld_q) begin
                        xfer_d      = pend_q;
                        req_d       = 1'b1;
                        src_state_d = S_REQ;
                        pend_vld_d  = 1'b0;
                    end
`endif
                end
            end
            default: begin
                src_state_d = S_IDLE;
                req_d       = 1'b0;
            end
        endcase

        // An update while busy is buffered or dropped; an overrun set beats a clear.
        if (upd_valid_i && busy_c) begin
`ifdef JTAG_CFG_XFER_PENDING_EN
            if (pend_vld_d) begin
                ovr_d = 1'b1;
            end
            pend_d     = upd_data_i;
            pend_vld_d = 1'b1;
`else
            ovr_d = 1'b1;
`endif
        end

`ifdef JTAG_CFG_XFER_PENDING_EN
        busy_d = (src_state_d != S_IDLE) || pend_vld_d;
`else
        busy_d = (src_state_d != S_IDLE);
`endif
    end

    // Source FSM and status registers.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            src_state_q <= S_IDLE;
            req_q       <= 1'b0;
            xfer_q      <= '0;
            ovr_q       <= 1'b0;
            busy_q      <= 1'b0;
`ifdef JTAG_CFG_XFER_PENDING_EN
            pend_vld_q  <= 1'b0;
            pend_q      <= '0;
`endif
        end else begin
            src_state_q <= src_state_d;
            req_q       <= req_d;
            xfer_q      <= xfer_d;
            ovr_q       <= ovr_d;
            busy_q      <= busy_d;
`ifdef JTAG_CFG_XFER_PENDING_EN
            pend_vld_q  <= pend_vld_d;
            pend_q      <= pend_d;
`endif
        end
    end

    assign busy_o = busy_q;
    assign ovr_o  = ovr_q;

    // ---------------- SoC clock domain ----------------
    dst_state_e       dst_state_q, dst_state_d;
    logic             ack_q, ack_d;
    logic [WIDTH-1:0] cfg_q, cfg_d;
    logic             cfg_valid_q, cfg_valid_d;
    logic             req_sync;

    // Destination FSM next state: capture xfer_q on req, release ack when req drops.
    always_comb begin
        dst_state_d = dst_state_q;
        ack_d       = ack_q;
        cfg_d       = cfg_q;
        cfg_valid_d = 1'b0;
        case (dst_state_q)
            D_IDLE: begin
                if (req_sync) begin
                    cfg_d       = xfer_q;
                    cfg_valid_d = 1'b1;
                    ack_d       = 1'b1;
                    dst_state_d = D_ACK;
                end
            end
            D_ACK: begin
                if (!req_sync) begin
                    ack_d       = 1'b0;
                    dst_state_d = D_IDLE;
                end
            end
            default: begin
                dst_state_d = D_IDLE;
                ack_d       = 1'b0;
            end
        endcase
    end

    // Destination FSM and delivered-word registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dst_state_q <= D_IDLE;
            ack_q       <= 1'b0;
            cfg_q       <= RESET_VAL;
            cfg_valid_q <= 1'b0;
        end else begin
            dst_state_q <= dst_state_d;
            ack_q       <= ack_d;
            cfg_q       <= cfg_d;
            cfg_valid_q <= cfg_valid_d;
        end
    end

    assign cfg_o       = cfg_q;
    assign cfg_valid_o = cfg_valid_q;

    // ---------------- Synchronizers ----------------
    jtag_cfg_xfer_sync #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (req_q),
        .q_o    (req_sync)
    );

    jtag_cfg_xfer_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
        .clk_i  (tck_i),
        .rst_ni (trst_ni),
        .d_i    (ack_q),
        .q_o    (ack_sync)
    );

endmodule
